parity_arb_ctrl: RTL

PARITY_ARB_CTRL -- requirements
Module: parity_arb_ctrl

---
 rtl/parity_arb_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/parity_arb_ctrl.sv
// Two-requester round-robin arbiter that serially computes the XOR parity of a 7-bit word.
// Optional macro PARITY_CMP_EN adds per-requester expected-parity inputs and a res_err output.
module parity_arb_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [6:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [6:0] req1_data,
  output logic       req1_ready,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_parity,
  output logic       res_id,
`ifdef PARITY_CMP_EN
  input  logic       req0_exp,
  input  logic       req1_exp,
  output logic       res_err,
`endif
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     r_state;
  logic [6:0] r_sr;
  logic       r_acc;
  logic [2:0] r_cnt;
  logic       r_id;
  logic       r_rr;
  logic       r_res_valid;
  logic       r_res_parity;
  logic       r_res_id;
  logic       r_busy;
`ifdef PARITY_CMP_EN
  logic       r_exp;
  logic       r_res_err;
`endif

  logic       w_gnt;
  logic       w_idle;
  logic       w_hs0;
  logic       w_hs1;
  logic       w_final_par;

  // Grant selection: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    w_gnt = 1'b0;
    if (req0_valid && req1_valid) begin
      w_gnt = ~r_rr;
    end else if (req1_valid) begin
      w_gnt = 1'b1;
    end else begin
      w_gnt = 1'b0;
    end
  end

  // Readys are gated by reset so every output reads 0 while rst is high.
  assign w_idle      = (r_state == IDLE) && !rst;
  assign w_hs0       = w_idle && req0_valid && !w_gnt;
  assign w_hs1       = w_idle && req1_valid && w_gnt;
  assign w_final_par = r_acc ^ r_sr[0];

  assign req0_ready  = w_hs0;
  assign req1_ready  = w_hs1;
  assign res_valid   = r_res_valid;
  assign res_parity  = r_res_parity;
  assign res_id      = r_res_id;
  assign busy        = r_busy;
`ifdef PARITY_CMP_EN
  assign res_err     = r_res_err;
`endif

  // Control FSM with datapath and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_sr         <= 7'd0;
      r_acc        <= 1'b0;
      r_cnt        <= 3'd0;
      r_id         <= 1'b0;
      r_rr         <= 1'b1;
      r_res_valid  <= 1'b0;
      r_res_parity <= 1'b0;
      r_res_id     <= 1'b0;
      r_busy       <= 1'b0;
`ifdef PARITY_CMP_EN
      r_exp        <= 1'b0;
      r_res_err    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hs0 || w_hs1) begin
            r_sr    <= w_hs1 ? req1_data : req0_data;
            r_acc   <= 1'b0;
            r_cnt   <= 3'd0;
            r_id    <= w_hs1;
`ifdef PARITY_CMP_EN
            r_exp   <= w_hs1 ? req1_exp : req0_exp;
`endif
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_acc <= w_final_par;
          r_sr  <= r_sr >> 1;
          if (r_cnt == 3'd6) begin
            r_cnt        <= 3'd0;
            r_res_valid  <= 1'b1;
            r_res_parity <= w_final_par;
            r_res_id     <= r_id;
`ifdef PARITY_CMP_EN
            r_res_err    <= w_final_par ^ r_exp;
`endif
            r_state      <= DONE;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        DONE: begin
          // Result is held until the consumer takes it; no acceptance in this cycle.
          if (res_ready) begin
            r_rr         <= r_id;
            r_res_valid  <= 1'b0;
            r_res_parity <= 1'b0;
            r_res_id     <= 1'b0;
`ifdef PARITY_CMP_EN
            r_res_err    <= 1'b0;
`endif
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_res_valid  <= 1'b0;
          r_res_parity <= 1'b0;
          r_res_id     <= 1'b0;
`ifdef PARITY_CMP_EN
          r_res_err    <= 1'b0;
`endif
          r_busy       <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

endmodule
